bo_datapath: RTL

Operative (datapath) block driven directly by the BC control FSM. It consumes BC's outputs LX, LS, LH, H, M0, M1 and M2 every cycle and evaluates a fixed-coefficient arithmetic sequence on an input operand: operand muxing, a registered add/multiply unit, and the X, H and S storage registers. It produces the final result plus a valid pulse and a sticky overflow flag for the next stage.

---
 rtl/bo_datapath_if.sv | 27 ++
 rtl/bo_datapath.sv | 85 ++++++++
 2 files changed

// File: rtl/bo_datapath_if.sv
// Control/data bundle between the BC control FSM (master) and the bo_datapath
// operative block (slave).
interface bo_datapath_if #(
    parameter int W = 8
) ();
    logic [W-1:0] x_in;
    logic         LX;
    logic         LH;
    logic         LS;
    logic         H;
    logic [1:0]   M0;
    logic [1:0]   M1;
    logic [1:0]   M2;
    logic [W-1:0] s_out;
    logic         valid_out;
    logic         ovf;

    modport master (
        output x_in, LX, LH, LS, H, M0, M1, M2,
        input  s_out, valid_out, ovf
    );

    modport slave (
        input  x_in, LX, LH, LS, H, M0, M1, M2,
        output s_out, valid_out, ovf
    );
endinterface

// File: rtl/bo_datapath.sv
// Operative block for BC: operand muxes, registered add/multiply unit (P),
// and the RX/RH/RS storage registers with a sticky overflow flag.
module bo_datapath #(
    parameter int           W  = 8,
    parameter logic [W-1:0] C0 = W'(2),
    parameter logic [W-1:0] C1 = W'(3),
    parameter logic [W-1:0] C2 = W'(5),
    parameter logic [W-1:0] C3 = W'(7)
) (
    input  logic         clk,
    input  logic         reset,
    bo_datapath_if.slave bus
);
    logic [W-1:0]   rx, rh, rs, p;
    logic           p_ovf, ovf_q, vld_q;
    logic [W-1:0]   coef, opa, opb;
    logic [2*W-1:0] prod;
    logic [W:0]     sum;
    logic [W-1:0]   p_nxt;
    logic           p_ovf_nxt;

    always_comb begin
        coef = C0;
        case (bus.M0)
            2'b00: coef = C0;
            2'b01: coef = C1;
            2'b10: coef = C2;
            2'b11: coef = C3;
        endcase
    end

    always_comb begin
        opa = '0;
        case (bus.M1)
            2'b00: opa = rh;
            2'b01: opa = rx;
            2'b10: opa = rs;
            2'b11: opa = '0;
        endcase
    end

    always_comb begin
        opb = coef;
        case (bus.M2)
            2'b00: opb = coef;
            2'b01: opb = rx;
            2'b10: opb = rh;
            2'b11: opb = rs;
        endcase
    end

    // Full-precision results so the discarded upper bits give the overflow.
    assign prod      = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
    assign sum       = {1'b0, opa} + {1'b0, opb};
    assign p_nxt     = bus.H ? prod[W-1:0] : sum[W-1:0];
    assign p_ovf_nxt = bus.H ? |prod[2*W-1:W] : sum[W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx    <= '0;
            rh    <= '0;
            rs    <= '0;
            p     <= '0;
            p_ovf <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            p     <= p_nxt;
            p_ovf <= p_ovf_nxt;
            vld_q <= bus.LS;
            if (bus.LX) rx <= bus.x_in;
            if (bus.LH) rh <= p;
            if (bus.LS) rs <= p;
            // A new operand starts a fresh sequence, so LX wins over a set.
            if (bus.LX)
                ovf_q <= 1'b0;
            else if ((bus.LH || bus.LS) && p_ovf)
                ovf_q <= 1'b1;
        end
    end

    assign bus.s_out     = rs;
    assign bus.valid_out = vld_q;
    assign bus.ovf       = ovf_q;
endmodule
